// File: rtl/seg7_pkg.sv
// seg7_pkg: shared active-high segment encoding for the scan driver
package seg7_pkg;
   localparam logic [7:0] SEG_OFF = 8'h00;
   localparam int DP_BIT = 7;
   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction
endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: nibble plus decimal point to active-high segment pattern
module seg7_hex_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   input  logic       dp,
   output logic [7:0] pat
);
   always_comb begin
      pat = SEG_OFF;
      pat[6:0] = hex_seg(nib);
      pat[DP_BIT] = dp;
   end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed N-digit 7-segment scanner with shadow load, blink,
// leading-zero blanking, PWM brightness and dead time
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int DIGITS       = 6,
   parameter int SCAN_DIV     = 896,
   parameter int BLINK_FRAMES = 64,
   parameter int SEL_ACT_LOW  = 0,
   parameter int SEG_ACT_LOW  = 1
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blink_mask,
   input  logic                  load,
   input  logic                  lz_blank,
   input  logic [3:0]            bright,
   input  logic                  disp_en,
   output logic [DIGITS-1:0]     sel,
   output logic [7:0]            seg,
   output logic                  frame_tick
);
   localparam int IW  = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam int PW  = $clog2(SCAN_DIV);
   localparam int SUB = SCAN_DIV / 16;
   localparam int SW  = $clog2(SUB);
   localparam int FW  = $clog2(BLINK_FRAMES + 1);
   localparam logic [DIGITS-1:0] SEL_POL = {DIGITS{SEL_ACT_LOW != 0}};
   localparam logic [7:0]        SEG_POL = {8{SEG_ACT_LOW != 0}};
   logic [4*DIGITS-1:0] sh_data;
   logic [DIGITS-1:0]   sh_dp, sh_blink, lz, sel_hi;
   logic [PW-1:0]       psc;
   logic [SW-1:0]       sub;
   logic [3:0]          ph, nib;
   logic [IW-1:0]       idx;
   logic [FW-1:0]       fcnt;
   logic                bph, slot_end, frame_end, sub_end, on, blank;
   logic [7:0]          pat, seg_hi;
   assign slot_end  = psc == PW'(SCAN_DIV - 1);
   assign frame_end = slot_end && idx == IW'(DIGITS - 1);
   assign sub_end   = sub == SW'(SUB - 1);
   // digit i is blanked when it and every digit above it are zero
   for (genvar i = 0; i < DIGITS; i++) begin : g_lz
      assign lz[i] = lz_blank && (i != 0) && sh_data[4*DIGITS-1:4*i] == '0;
   end
   assign nib = sh_data[{idx, 2'b00} +: 4];
   seg7_hex_decoder u_dec (
      .nib (nib),
      .dp  (sh_dp[idx]),
      .pat (pat)
   );
   always_comb begin
      on     = disp_en && ph <= bright && psc != '0;
      blank  = (sh_blink[idx] && bph) || lz[idx];
      sel_hi = on ? DIGITS'(1) << idx : '0;
      seg_hi = blank ? SEG_OFF : pat;
   end
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         sh_data    <= '0;
         sh_dp      <= '0;
         sh_blink   <= '0;
         psc        <= '0;
         sub        <= '0;
         ph         <= '0;
         idx        <= '0;
         fcnt       <= '0;
         bph        <= 1'b0;
         frame_tick <= 1'b0;
         sel        <= SEL_POL;
         seg        <= SEG_OFF ^ SEG_POL;
      end else begin
         if (load) begin
            sh_data  <= data;
            sh_dp    <= dp;
            sh_blink <= blink_mask;
         end
         psc <= slot_end ? '0 : psc + 1'b1;
         sub <= sub_end ? '0 : sub + 1'b1;
         ph  <= ph + {3'b000, sub_end};
         if (slot_end)
            idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
         if (frame_end) begin
            fcnt <= fcnt == FW'(BLINK_FRAMES - 1) ? '0 : fcnt + 1'b1;
            bph  <= fcnt == FW'(BLINK_FRAMES - 1) ? ~bph : bph;
         end
         frame_tick <= frame_end;
         sel        <= sel_hi ^ SEL_POL;
         seg        <= seg_hi ^ SEG_POL;
      end
   end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized and directed checks of the scanner against a
// cycle-count based behavioural model
module tb_seg7_scan_ctrl;
   localparam int D  = 6;
   localparam int SD = 32;
   localparam int BF = 2;
   logic          sys_clk, sys_rst, load, lz_blank, disp_en, frame_tick;
   logic [23:0]   data;
   logic [5:0]    dp, blink_mask, sel;
   logic [3:0]    bright;
   logic [7:0]    seg;
   int            total = 0, bad = 0, act;
   logic [7:0]    fs [6];
   bit            chk_en = 0;
   logic [5:0]    exp_sel;
   logic [7:0]    exp_seg;
   logic          exp_ft;
   int unsigned   k;
   logic [23:0]   m_data;
   logic [5:0]    m_dp, m_bl;

   seg7_scan_ctrl #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
                    .SEL_ACT_LOW(0), .SEG_ACT_LOW(1)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .data(data), .dp(dp),
      .blink_mask(blink_mask), .load(load), .lz_blank(lz_blank),
      .bright(bright), .disp_en(disp_en), .sel(sel), .seg(seg),
      .frame_tick(frame_tick));

   initial sys_clk = 0;
   always #5 sys_clk = ~sys_clk;

   function automatic logic [6:0] hex7(input int n);
      logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[n];
   endfunction

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
      end
   endtask

   // model: everything follows from the number of clocks since reset
   always @(posedge sys_clk or negedge sys_rst) begin
      int p, id, ph, nib;
      logic bp, blank;
      if (!sys_rst) begin
         k <= 0; m_data <= '0; m_dp <= '0; m_bl <= '0;
         exp_sel <= '0; exp_seg <= 8'hFF; exp_ft <= 1'b0;
      end else begin
         p     = int'(k % SD);
         id    = int'((k / SD) % D);
         ph    = p / (SD / 16);
         bp    = ((k / (SD * D * BF)) % 2) == 1;
         nib   = int'((m_data >> (4 * id)) & 24'hF);
         blank = (m_bl[id] && bp) || (lz_blank && id != 0 && (m_data >> (4 * id)) == 0);
         exp_sel <= (disp_en && ph <= int'(bright) && p != 0) ? 6'(1 << id) : 6'd0;
         exp_seg <= blank ? 8'hFF : ~{m_dp[id], hex7(nib)};
         exp_ft  <= (k % (SD * D)) == SD * D - 1;
         if (load) begin
            m_data <= data; m_dp <= dp; m_bl <= blink_mask;
         end
         k <= k + 1;
      end
   end

   always @(negedge sys_clk) if (chk_en) begin
      chk("sel", 32'(sel), 32'(exp_sel));
      chk("seg", 32'(seg), 32'(exp_seg));
      chk("frame_tick", 32'(frame_tick), 32'(exp_ft));
   end

   task automatic wait_ft();
      int n = 0;
      while (frame_tick !== 1'b1 && n < 400) begin
         @(negedge sys_clk);
         n++;
      end
      if (frame_tick !== 1'b1) begin
         total++; bad++;
         $display("FAIL frame_tick_timeout: no tick within %0d cycles", n);
      end
   endtask

   // capture the frame following a tick: last seg seen per digit and lit-cycle count
   task automatic grab();
      wait_ft();
      act = 0;
      for (int j = 0; j < 6; j++) fs[j] = 8'h00;
      for (int c = 0; c < SD * D; c++) begin
         @(negedge sys_clk);
         if (sel != 0) begin
            act++;
            for (int j = 0; j < 6; j++) if (sel[j]) fs[j] = seg;
         end
      end
   endtask

   task automatic do_load(input logic [23:0] d, input logic [5:0] p, input logic [5:0] b);
      @(negedge sys_clk);
      data = d; dp = p; blink_mask = b; load = 1;
      @(negedge sys_clk);
      load = 0;
   endtask

   task automatic chk_frame(input string name, input logic [47:0] e);
      for (int j = 0; j < 6; j++) chk(name, 32'(fs[j]), 32'(e[8*j +: 8]));
   endtask

   task automatic pulse_reset();
      @(negedge sys_clk);
      #3 sys_rst = 0;
      #1;
      chk("async_rst_sel", 32'(sel), 32'h0);
      chk("async_rst_seg", 32'(seg), 32'hFF);
      chk("async_rst_ft", 32'(frame_tick), 32'h0);
      @(negedge sys_clk);
      sys_rst = 1;
      @(negedge sys_clk);
      chk("restart_dead", 32'(sel), 32'h0);
      @(negedge sys_clk);
      chk("restart_digit0", 32'(sel), 32'h1);
   endtask

   function automatic logic [23:0] rnd_data();
      logic [23:0] r = '0;
      for (int j = 0; j < 6; j++) r[4*j +: 4] = $urandom_range(1) == 1 ? 4'h0 : 4'($urandom_range(15));
      return r;
   endfunction

   initial begin
      sys_rst = 0; load = 0; data = '0; dp = '0; blink_mask = '0;
      lz_blank = 0; bright = 4'd15; disp_en = 1;
      repeat (3) @(negedge sys_clk);
      chk_en = 1;
      chk("reset_sel", 32'(sel), 32'h0);
      chk("reset_seg", 32'(seg), 32'hFF);
      sys_rst = 1;
      do_load(24'h12AB3F, 6'd0, 6'd0);
      grab();
      chk_frame("hex_frame", 48'hF9_A4_88_83_B0_8E);
      chk("lit_b15", act, 186);
      @(negedge sys_clk);
      wait_ft();
      chk("ft_seen", 32'(frame_tick), 32'h1);
      act = 0;
      do begin @(negedge sys_clk); act++; end while (frame_tick !== 1'b1 && act < 400);
      chk("ft_period", act, 192);
      bright = 4'd0;
      grab();
      chk("lit_b0", act, 6);
      bright = 4'd7;
      grab();
      chk("lit_b7", act, 90);
      bright = 4'd15;
      lz_blank = 1;
      do_load(24'h000400, 6'd0, 6'd0);
      grab();
      chk_frame("lz_frame", 48'hFF_FF_FF_99_C0_C0);
      do_load(24'h000000, 6'd0, 6'd0);
      grab();
      chk_frame("lz_zero", 48'hFF_FF_FF_FF_FF_C0);
      @(negedge sys_clk);
      data = 24'h987654; dp = 6'h3F;
      grab();
      chk_frame("no_load", 48'hFF_FF_FF_FF_FF_C0);
      lz_blank = 0;
      pulse_reset();
      do_load(24'h000000, 6'd0, 6'b000001);
      grab();
      chk("blink_f1_d0", 32'(fs[0]), 32'hC0);
      grab();
      chk("blink_f2_d0", 32'(fs[0]), 32'hFF);
      chk("blink_f2_d1", 32'(fs[1]), 32'hC0);
      grab();
      chk("blink_f3_d0", 32'(fs[0]), 32'hFF);
      grab();
      chk("blink_f4_d0", 32'(fs[0]), 32'hC0);
      disp_en = 0;
      grab();
      chk("disp_off", act, 0);
      disp_en = 1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge sys_clk);
         load = $urandom_range(19) == 0;
         if ($urandom_range(7) == 0) begin
            data = rnd_data(); dp = 6'($urandom); blink_mask = 6'($urandom);
         end
         if ($urandom_range(99) == 0) lz_blank = ~lz_blank;
         if ($urandom_range(49) == 0) bright = 4'($urandom);
         if ($urandom_range(99) == 0) disp_en = $urandom_range(3) != 0;
         if (c == 2500) begin
            load = 0;
            pulse_reset();
         end
      end
      load = 0;
      repeat (2) @(negedge sys_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
